// File: rtl/ib_lut_ram_loader_if.sv
// ib_lut_ram_loader_if: LUT word stream (in_data/in_valid/in_ready) plus the
// function-RAM write bus (page_addr_ram/ram_write_data/ib_ram_we).
// The slave modport is the loader's view; the master modport is the view of
// whatever supplies the stream and observes the write bus.
interface ib_lut_ram_loader_if #(
  parameter int LUT_W      = 6,
  parameter int ENTRY_ADDR = 6
);
  logic [LUT_W-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ENTRY_ADDR-1:0] page_addr_ram;
  logic [LUT_W-1:0]      ram_write_data;
  logic                  ib_ram_we;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output page_addr_ram,
    output ram_write_data,
    output ib_ram_we
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  page_addr_ram,
    input  ram_write_data,
    input  ib_ram_we
  );
endinterface

// File: rtl/ib_lut_ram_loader.sv
// ib_lut_ram_loader: writer side of the IB-CNU function-RAM iteration-update
// port. Streams one frame of PAGE_NUM LUT words into the sym_cn_lut_out RAMs.
// The address MSB is the frame offset latched with update_req.
// Optional macro IB_LOAD_CHECKSUM_EN adds expected_sum/sum_err and a running
// XOR check of all accepted words.
//
// state | meaning
// IDLE  | waiting for update_req
// LOAD  | accepting beats, one RAM write per accepted beat one cycle later
// FLUSH | last page write on the bus, no more beats accepted
// DONE  | load_done pulse, back to IDLE
module ib_lut_ram_loader #(
  parameter int QUAN_SIZE     = 4,
  parameter int ENTRY_ADDR    = 6,
  parameter int BANK_NUM      = 2,
  parameter int LUT_PORT_SIZE = 3,
  parameter int PAGE_NUM      = 32
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              update_req,
  input  logic                              update_frame,
`ifdef IB_LOAD_CHECKSUM_EN
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] expected_sum,
  output logic                              sum_err,
`endif
  output logic                              busy,
  output logic                              load_done,
  output logic                              req_dropped,
  ib_lut_ram_loader_if.slave                bus
);
  localparam int LUT_W  = LUT_PORT_SIZE * BANK_NUM;
  localparam int PAGE_W = ENTRY_ADDR - 1;
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGE_NUM - 1);

  // QUAN_SIZE only exists so all IB-CNU blocks share one parameter list.
  if (QUAN_SIZE <= 0) begin : g_quan_size_invalid
  end

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t                state_q, state_d;
  logic [PAGE_W-1:0]     page_cnt_q, page_cnt_d;
  logic                  frame_q, frame_d;
  logic [ENTRY_ADDR-1:0] addr_q, addr_d;
  logic [LUT_W-1:0]      data_q, data_d;
  logic                  we_q, we_d;
  logic                  load_done_q, load_done_d;
  logic                  req_dropped_q, req_dropped_d;
  logic                  in_ready_c;
`ifdef IB_LOAD_CHECKSUM_EN
  logic [LUT_W-1:0]      sum_q, sum_d;
  logic [LUT_W-1:0]      exp_q, exp_d;
  logic                  sum_err_q, sum_err_d;
`endif

  // Next-state, write-bus and pulse computation.
  always_comb begin
    state_d       = state_q;
    page_cnt_d    = page_cnt_q;
    frame_d       = frame_q;
    addr_d        = addr_q;
    data_d        = data_q;
    we_d          = 1'b0;
    load_done_d   = 1'b0;
    req_dropped_d = update_req && (state_q != IDLE);
    in_ready_c    = 1'b0;
`ifdef IB_LOAD_CHECKSUM_EN
    sum_d         = sum_q;
    exp_d         = exp_q;
    sum_err_d     = sum_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (update_req) begin
          frame_d    = update_frame;
          page_cnt_d = '0;
          state_d    = LOAD;
`ifdef IB_LOAD_CHECKSUM_EN
          sum_d      = '0;
          exp_d      = expected_sum;
          sum_err_d  = 1'b0;
`endif
        end
      end
      LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          we_d   = 1'b1;
          data_d = bus.in_data;
          addr_d = {frame_q, page_cnt_q};
`ifdef IB_LOAD_CHECKSUM_EN
          sum_d  = sum_q ^ bus.in_data;
`endif
          // The terminal beat leaves LOAD, so the counter never wraps.
          if (page_cnt_q == LAST_PAGE) begin
            state_d = FLUSH;
          end else begin
            page_cnt_d = page_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        load_done_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
`ifdef IB_LOAD_CHECKSUM_EN
        sum_err_d = (sum_q != exp_q);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears the write bus immediately.
  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      page_cnt_q    <= '0;
      frame_q       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
      load_done_q   <= 1'b0;
      req_dropped_q <= 1'b0;
`ifdef IB_LOAD_CHECKSUM_EN
      sum_q         <= '0;
      exp_q         <= '0;
      sum_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      page_cnt_q    <= page_cnt_d;
      frame_q       <= frame_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      we_q          <= we_d;
      load_done_q   <= load_done_d;
      req_dropped_q <= req_dropped_d;
`ifdef IB_LOAD_CHECKSUM_EN
      sum_q         <= sum_d;
      exp_q         <= exp_d;
      sum_err_q     <= sum_err_d;
`endif
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.page_addr_ram  = addr_q;
  assign bus.ram_write_data = data_q;
  assign bus.ib_ram_we      = we_q;
  assign busy               = (state_q == LOAD) || (state_q == FLUSH);
  assign load_done          = load_done_q;
  assign req_dropped        = req_dropped_q;
`ifdef IB_LOAD_CHECKSUM_EN
  assign sum_err            = sum_err_q;
`endif
endmodule

// File: tb/tb_ib_lut_ram_loader.sv
// Bench for ib_lut_ram_loader: accepted beats are pushed to a scoreboard and
// popped when the matching RAM write appears on the bus.
module tb_ib_lut_ram_loader;
  localparam int W  = 6;
  localparam int EA = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic update_req = 1'b0;
  logic update_frame = 1'b0;
  logic busy, load_done, req_dropped;
`ifdef IB_LOAD_CHECKSUM_EN
  logic [W-1:0] expected_sum = '0;
  logic sum_err;
`endif

  ib_lut_ram_loader_if #(.LUT_W(W), .ENTRY_ADDR(EA)) ifc ();

  ib_lut_ram_loader dut (
    .write_clk    (clk),
    .rst          (rst),
    .update_req   (update_req),
    .update_frame (update_frame),
`ifdef IB_LOAD_CHECKSUM_EN
    .expected_sum (expected_sum),
    .sum_err      (sum_err),
`endif
    .busy         (busy),
    .load_done    (load_done),
    .req_dropped  (req_dropped),
    .bus          (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_cyc = 0;
  int wr_cnt = 0;
  int drop_cnt = 0;
  int spurious = 0;
  logic [EA+W-1:0] sb[$];
  logic [EA+W-1:0] exp_w;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-bus monitor: every write must match the oldest accepted beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.ib_ram_we === 1'b1) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          spurious++;
        end else begin
          exp_w = sb.pop_front();
          check("wr_addr", 32'(ifc.page_addr_ram), 32'(exp_w[EA+W-1:W]));
          check("wr_data", 32'(ifc.ram_write_data), 32'(exp_w[W-1:0]));
        end
      end
      if (req_dropped === 1'b1) drop_cnt++;
    end
  end

  task automatic drive_load(input logic frame, input bit gapped, input bit toggle_frame,
                            input int drop_at, input int stop_after, input logic [W-1:0] dxor);
    int page = 0;
    int guard = 0;
    bit vld;
    bit dropped = 0;
    logic [EA-2:0] pg;
    @(negedge clk);
    wr_cnt = 0;
    update_frame = frame;
    update_req = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    update_req = 1'b0;
    while (page < stop_after && guard < 200) begin
      guard++;
      vld = gapped ? ((guard % 2) == 1) : 1'b1;
      pg = page[EA-2:0];
      ifc.in_valid = vld;
      ifc.in_data = W'(page) ^ dxor;
      if (toggle_frame) update_frame = ~update_frame;
      update_req = (!dropped && page == drop_at);
      if (update_req) dropped = 1;
      if (vld && ifc.in_ready === 1'b1) begin
        sb.push_back({frame, pg, W'(page) ^ dxor});
        page++;
      end
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
    update_req = 1'b0;
    check("beat_budget", page, stop_after);
  endtask

  task automatic finish_load(input bit timed);
    int k = 0;
    check("flush_busy", busy, 1);
    check("flush_ready", ifc.in_ready, 0);
    while (load_done !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", load_done, 1);
    check("done_busy", busy, 0);
    if (timed) check("done_latency", cyc - req_cyc, 34);
    @(negedge clk);
    check("done_pulse", load_done, 0);
    check("wr_count", wr_cnt, 32);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_we", ifc.ib_ram_we, 0);
    check("rst_addr", ifc.page_addr_ram, 0);
    check("rst_data", ifc.ram_write_data, 0);
    check("rst_ready", ifc.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", load_done, 0);
    check("rst_drop", req_dropped, 0);
    rst = 1'b0;

    ifc.in_valid = 1'b1;
    ifc.in_data = 6'h2A;
    repeat (4) begin
      @(negedge clk);
      check("idle_we", ifc.ib_ram_we, 0);
      check("idle_ready", ifc.in_ready, 0);
      check("idle_busy", busy, 0);
    end
    ifc.in_valid = 1'b0;

    // Full frame 1, continuous valid, data = page index.
    drop_cnt = 0;
    drive_load(1'b1, 1'b0, 1'b0, -1, 32, 6'h00);
    finish_load(1'b1);
    check("no_drop_full", drop_cnt, 0);
`ifdef IB_LOAD_CHECKSUM_EN
    check("sum_ok", sum_err, 0);
`endif

    // Gapped stream, frame 0.
    drive_load(1'b0, 1'b1, 1'b0, -1, 32, 6'h15);
    finish_load(1'b0);

    // Request during load at page 10, frame input toggling mid-load.
    drop_cnt = 0;
    drive_load(1'b1, 1'b0, 1'b1, 10, 32, 6'h0A);
    finish_load(1'b1);
    check("drop_count", drop_cnt, 1);

    // Reset mid-load after page 15, then a fresh full load.
    drive_load(1'b0, 1'b0, 1'b0, -1, 16, 6'h00);
    #1;
    check("pre_rst_we", ifc.ib_ram_we, 1);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_addr", ifc.page_addr_ram, 6'h0F);
    rst = 1'b1;
    #1;
    check("mid_rst_we", ifc.ib_ram_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", ifc.page_addr_ram, 0);
    check("mid_rst_data", ifc.ram_write_data, 0);
    check("mid_rst_ready", ifc.in_ready, 0);
    check("mid_rst_sb", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_load(1'b0, 1'b0, 1'b0, -1, 32, 6'h33);
    finish_load(1'b1);

`ifdef IB_LOAD_CHECKSUM_EN
    expected_sum = 6'h01;
    drive_load(1'b1, 1'b0, 1'b0, -1, 32, 6'h00);
    finish_load(1'b1);
    check("sum_err_set", sum_err, 1);
`endif

    check("spurious_writes", spurious, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
